pipe_seq_ctl: RTL

Pipeline sequencing controller for the mips789 fetch/decode datapath. It drives pc_gen's pc_prectl and pause inputs and reg_array's pause and rd_clk_cls inputs. It sequences the post-reset PC hold, stall and hazard holds, and the multi-cycle interrupt entry (EPC save, vector jump, acknowledge). It sits beside the decoder and arbitrates between memory/mul-div stalls, load-use hazards and external interrupt requests.

---
 rtl/pipe_seq_ctl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_seq_ctl.sv
// Pipeline sequencing controller for the mips789 fetch/decode datapath.
// It drives the pc_gen and reg_array control inputs (pc_prectl, pause,
// rd_clk_cls). It sequences the post-reset PC hold, the stall and hazard
// holds, and the multi-cycle interrupt entry: save EPC, jump to the vector,
// then acknowledge.
//
// Handshake semantics: there is no valid/ready pair here. pause is a
// zero-latency freeze: whenever it is high, state and counters hold, and every
// one-shot side effect (epc_wr, irq_ack, flush_id, flush_ex) is suppressed.
// The held cycle is therefore repeated later with its effects intact.
// An accepted interrupt always runs to completion, even if irq_req drops.
module pipe_seq_ctl #(
  parameter int RST_CYCLES = 4,
  parameter int IRQ_GAP    = 2
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       ext_stall,
  input  logic       muldiv_busy,
  input  logic       load_use,
  input  logic       in_dslot,
  input  logic       irq_req,
  input  logic       irq_en,
  output logic [3:0] pc_prectl,
  output logic       pause,
  output logic       rd_clk_cls,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       epc_wr,
  output logic       irq_ack,
  output logic       busy_irq,
  output logic [2:0] state_dbg
);

  // pc_gen control codes, matching mips789_defs.v
  localparam logic [3:0] PC_IGN = 4'b0001;
  localparam logic [3:0] PC_KEP = 4'b0010;
  localparam logic [3:0] PC_IRQ = 4'b0100;
  localparam logic [3:0] PC_RST = 4'b1000;

  localparam logic [7:0] RST_INIT = 8'(RST_CYCLES - 1);
  localparam logic [3:0] GAP_INIT = 4'(IRQ_GAP);

  typedef enum logic [2:0] {
    ST_RST      = 3'd0,
    ST_RUN      = 3'd1,
    ST_IRQ_SAVE = 3'd2,
    ST_IRQ_JUMP = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] rst_cnt, rst_cnt_nxt;
  logic [3:0] gap_cnt, gap_cnt_nxt;
  logic       stall;

  assign stall     = ext_stall | muldiv_busy;
  assign state_dbg = state;

  // State and counter registers; reset forces the RST hold asynchronously
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RST;
      rst_cnt <= RST_INIT;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rst_cnt <= rst_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Next-state and output decode; priority is pause > load_use hold > irq accept
  always_comb begin
    state_nxt   = state;
    rst_cnt_nxt = rst_cnt;
    gap_cnt_nxt = gap_cnt;
    pc_prectl   = PC_IGN;
    pause       = 1'b0;
    rd_clk_cls  = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    epc_wr      = 1'b0;
    irq_ack     = 1'b0;
    busy_irq    = 1'b0;

    if (state == ST_RST) begin
      // Stall and interrupt inputs are ignored until the PC hold expires
      pc_prectl = PC_RST;
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
      if (rst_cnt == 8'd0) state_nxt = ST_RUN;
      else                 rst_cnt_nxt = rst_cnt - 8'd1;
    end else begin
      pause    = stall;
      busy_irq = (state != ST_RUN);
      if (stall) begin
        pc_prectl = PC_KEP;
      end else begin
        case (state)
          ST_RUN, ST_GAP: begin
            if (load_use) begin
              pc_prectl  = PC_KEP;
              rd_clk_cls = 1'b1;
              flush_ex   = 1'b1;
            end
            if (state == ST_RUN) begin
              // Never enter on a delay slot or a hazard-held instruction
              if (irq_req && irq_en && !load_use && !in_dslot)
                state_nxt = ST_IRQ_SAVE;
            end else if (gap_cnt == 4'd0) begin
              state_nxt = ST_RUN;
            end else begin
              gap_cnt_nxt = gap_cnt - 4'd1;
            end
          end
          ST_IRQ_SAVE: begin
            epc_wr    = 1'b1;
            pc_prectl = PC_KEP;
            flush_id  = 1'b1;
            state_nxt = ST_IRQ_JUMP;
          end
          ST_IRQ_JUMP: begin
            pc_prectl   = PC_IRQ;
            flush_id    = 1'b1;
            flush_ex    = 1'b1;
            irq_ack     = 1'b1;
            state_nxt   = ST_GAP;
            gap_cnt_nxt = GAP_INIT;
          end
          default: state_nxt = ST_RST;
        endcase
      end
    end
  end

endmodule
